dac_playback_ctrl: RTL and testbench
====================================

Name: dac_playback_ctrl

Overview:
- Sequences the 8-bit DAC datapath. Paces reads from the playback sample FIFO at a fixed sample rate derived from the system clock.
- Pre-buffers the FIFO before playback starts, detects and counts underruns, and soft-ramps the DAC code to mid-scale when stopped to avoid clicks.
- Sits between the audio FIFO read port and the DAC output stage. The DAC output stage does its own code inversion; this block delivers raw samples.

Parameters:
- CLK_DIV, 50: system clocks per sample tick; legal range >= 2.
- FIFO_AW, 10: FIFO address width; the level port is FIFO_AW+1 bits.
- PREFILL, 256: FIFO level required before leaving PREFILL; range 0..2^FIFO_AW.
- IDLE_CODE, 8'd128: mid-scale code held when stopped.

Ports:
- clk  in  1  system clock; also the FIFO read clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  playback request.
- clr_stats  in  1  one-cycle pulse; clears underrun_cnt.
- fifo_empty  in  1  FIFO empty flag.
- fifo_level  in  FIFO_AW+1  FIFO fill level.
- fifo_rd_data  in  8  FIFO read data; standard FIFO, valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO read strobe.
- da_data  out  8  sample to the DAC output stage.
- da_valid  out  1  one-cycle pulse when da_data changes.
- state  out  2  current state: IDLE=0, PREFILL=1, PLAY=2.
- underrun  out  1  one-cycle pulse on each underrun.
- underrun_cnt  out  16  underrun count; saturates at 16'hFFFF.

Behaviour:
- Reset values: state=IDLE, da_data=IDLE_CODE, da_valid=0, fifo_rd_en=0, underrun=0, underrun_cnt=0, tick counter=0, rd_pending=0.
- Tick counter:
  - Free-running 0..CLK_DIV-1 in every state.
  - Registered tick=1 for one cycle when the counter wraps, giving exactly one tick per CLK_DIV clocks.
  - First tick after reset occurs in cycle CLK_DIV.
- IDLE:
  - enable=1 → PREFILL on the next edge.
  - On each tick, if da_data != IDLE_CODE, step da_data by 1 toward IDLE_CODE and pulse da_valid.
  - Once da_data = IDLE_CODE, no further da_valid pulses.
- PREFILL:
  - enable=0 → IDLE.
  - Else fifo_level >= PREFILL → PLAY.
  - No reads are issued. da_data holds its value.
  - With PREFILL=0, the block spends exactly one cycle in PREFILL.
- PLAY:
  - enable=0 → IDLE; this takes priority over a coincident tick.
  - On tick with fifo_empty=0: fifo_rd_en=1 (combinational, only in the tick cycle N).
    - rd_pending=1 in cycle N+1.
    - At the end of N+1, da_data<=fifo_rd_data and da_valid=1 during N+2.
    - Read-to-output latency is 2 cycles; at most one read per tick.
  - On tick with fifo_empty=1: no read; da_data holds the last sample.
    - underrun=1 for one cycle; underrun_cnt increments (saturating).
    - state → PREFILL.
- Disable with a read in flight (rd_pending=1 when the state leaves PLAY): the in-flight data is discarded. da_data is not updated by it and no da_valid pulse is produced.
- clr_stats coincident with an underrun: the clear wins and underrun_cnt=0.
- enable toggling: the tick counter is never reset by enable, so sample spacing stays exact across stop/start.
- fifo_rd_en is never asserted outside PLAY and never when fifo_empty=1, so the FIFO is never read while empty.
- da_data changes only on da_valid cycles.

Test Plan:
- Reset and tick timing (CLK_DIV=4): release reset, enable=0.
  - state=0, da_data=128, da_valid and fifo_rd_en stay 0.
  - Internal tick fires at cycles 4, 8, 12.
- Prefill then play (CLK_DIV=4, PREFILL=8, FIFO preloaded 0x10..0x1F, level=16): enable=1.
  - PREFILL lasts one cycle, then PLAY.
  - fifo_rd_en pulses once every 4 clocks.
  - da_data sequence 0x10,0x11,...; each update 2 cycles after its rd_en, with a da_valid pulse.
- Underrun: FIFO holding 2 samples (0xA0, 0xA1) while in PLAY.
  - Output 0xA0, 0xA1.
  - At the next tick: fifo_rd_en=0, underrun pulse, underrun_cnt=1, state=PREFILL, da_data holds 0xA1.
  - After refilling to level 8: PLAY resumes.
- Soft ramp: da_data=0x84 when enable drops.
  - state=IDLE next cycle.
  - da_data goes 0x83, 0x82, 0x81, 0x80 on four consecutive ticks with 4 da_valid pulses, then no more pulses.
  - Repeat from 0x7C: ramps up to 0x80.
- Disable mid-read: drop enable in the cycle after fifo_rd_en (rd_pending=1).
  - da_data unchanged, no da_valid pulse, state=IDLE.
  - Ramp begins at the next tick.
- Counter saturation and clear: force 65,536 underruns.
  - underrun_cnt=16'hFFFF and holds.
  - Assert clr_stats in the same cycle as an underrun pulse: underrun_cnt=0.

Source files
------------

// File: rtl/dac_playback_ctrl.sv
// dac_playback_ctrl: paces 8-bit sample reads from the playback FIFO at a
// fixed sample rate, pre-buffers before playback, counts underruns and ramps
// the DAC code back to mid-scale when stopped so the output does not click.
module dac_playback_ctrl #(
  parameter int unsigned CLK_DIV   = 50,
  parameter int unsigned FIFO_AW   = 10,
  parameter int unsigned PREFILL   = 256,
  parameter logic [7:0]  IDLE_CODE = 8'd128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clr_stats,
  input  logic               fifo_empty,
  input  logic [FIFO_AW:0]   fifo_level,
  input  logic [7:0]         fifo_rd_data,
  output logic               fifo_rd_en,
  output logic [7:0]         da_data,
  output logic               da_valid,
  output logic [1:0]         state,
  output logic               underrun,
  output logic [15:0]        underrun_cnt
);

  localparam int unsigned       CNT_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0]  PREFILL_LVL = (FIFO_AW + 1)'(PREFILL);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_PLAY    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic              rd_pending_q, rd_pending_d;
  logic [7:0]        da_data_q, da_data_d;
  logic              da_valid_q, da_valid_d;
  logic              underrun_q, underrun_d;
  logic [15:0]       underrun_cnt_q, underrun_cnt_d;
  logic              rd_en;

  // Next-state logic: sample pacing, playback FSM, soft ramp and statistics.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    da_data_d      = da_data_q;
    da_valid_d     = 1'b0;
    underrun_d     = 1'b0;
    underrun_cnt_d = underrun_cnt_q;
    rd_en          = 1'b0;

    // Tick counter runs in every state and is never touched by enable, so the
    // sample spacing is preserved across stop/start.
    if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
      tick_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_PREFILL;
        end
        // Step one code per tick toward mid-scale to avoid an audible click.
        if (tick_q && (da_data_q != IDLE_CODE)) begin
          da_data_d  = (da_data_q < IDLE_CODE) ? da_data_q + 8'd1 : da_data_q - 8'd1;
          da_valid_d = 1'b1;
        end
      end

      ST_PREFILL: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (fifo_level >= PREFILL_LVL) begin
          state_d = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (!enable) begin
          // Leaving PLAY drops any read still in flight.
          state_d = ST_IDLE;
        end else begin
          if (rd_pending_q) begin
            da_data_d  = fifo_rd_data;
            da_valid_d = 1'b1;
          end
          if (tick_q) begin
            if (!fifo_empty) begin
              rd_en = 1'b1;
            end else begin
              underrun_d = 1'b1;
              state_d    = ST_PREFILL;
              if (underrun_cnt_q != 16'hFFFF) begin
                underrun_cnt_d = underrun_cnt_q + 16'd1;
              end
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A clear coincident with an underrun wins.
    if (clr_stats) begin
      underrun_cnt_d = '0;
    end

    rd_pending_d = rd_en;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of statement order.
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      tick_q         <= 1'b0;
      rd_pending_q   <= 1'b0;
      da_data_q      <= IDLE_CODE;
      da_valid_q     <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tick_q         <= tick_d;
      rd_pending_q   <= rd_pending_d;
      da_data_q      <= da_data_d;
      da_valid_q     <= da_valid_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign fifo_rd_en   = rd_en;
  assign da_data      = da_data_q;
  assign da_valid     = da_valid_q;
  assign state        = state_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Directed testbench for dac_playback_ctrl with a small behavioural FIFO.
// Cycle numbering: cyc = number of rising edges since reset release; outputs
// are sampled on the falling edge that follows.
module tb_dac_playback_ctrl;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned FIFO_AW = 10;
  localparam int unsigned PREFILL = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               clr_stats;
  logic               fifo_empty;
  logic [FIFO_AW:0]   fifo_level;
  logic [7:0]         fifo_rd_data;
  logic               fifo_rd_en;
  logic [7:0]         da_data;
  logic               da_valid;
  logic [1:0]         state;
  logic               underrun;
  logic [15:0]        underrun_cnt;

  logic [7:0] fifo_q[$];
  int         cyc;
  int         n_pass;
  int         n_fail;
  int         n_total;
  logic [7:0] exp_da;
  logic       exp_valid;

  always #5 clk = ~clk;

  dac_playback_ctrl #(
    .CLK_DIV  (CLK_DIV),
    .FIFO_AW  (FIFO_AW),
    .PREFILL  (PREFILL),
    .IDLE_CODE(8'd128)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clr_stats   (clr_stats),
    .fifo_empty  (fifo_empty),
    .fifo_level  (fifo_level),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .da_data     (da_data),
    .da_valid    (da_valid),
    .state       (state),
    .underrun    (underrun),
    .underrun_cnt(underrun_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic sync_flags();
    fifo_level = (FIFO_AW + 1)'(fifo_q.size());
    fifo_empty = (fifo_q.size() == 0);
  endtask

  // Advance one clock; models the FIFO read port (data valid after rd_en).
  task automatic step();
    logic       rd;
    logic [7:0] da_before;
    #1;
    rd        = fifo_rd_en;
    da_before = da_data;
    check("rd_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
    @(posedge clk);
    cyc++;
    #1;
    if (rd && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
    sync_flags();
    @(negedge clk);
    if (da_data !== da_before) check("da_change_has_valid", 32'(da_valid), 32'd1);
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  // Enter PLAY, drain the FIFO, and take the next tick as an underrun.
  task automatic force_underrun(input logic clr);
    fifo_q.delete();
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'h55);
    sync_flags();
    enable = 1'b1;
    for (int i = 0; i < 8 && state != 2'd2; i++) step();
    check("reach_play", 32'(state), 32'd2);
    fifo_q.delete();
    sync_flags();
    for (int i = 0; i < 8 && (cyc % 4) != 0; i++) step();
    clr_stats = clr;
    step();
    clr_stats = 1'b0;
    check("sat_underrun_pulse", 32'(underrun), 32'd1);
    check("sat_state_prefill", 32'(state), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0; cyc = 0;
    reset = 1'b1; enable = 1'b0; clr_stats = 1'b0; fifo_rd_data = 8'h00;
    fifo_q.delete();
    sync_flags();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values.
    check("rst_state", 32'(state), 32'd0);
    check("rst_da_data", 32'(da_data), 32'h80);
    check("rst_da_valid", 32'(da_valid), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_cnt", 32'(underrun_cnt), 32'd0);

    // Tick timing in IDLE: tick in cycles 4, 8, 12.
    for (int i = 0; i < 13; i++) begin
      step();
      check("tick", 32'(dut.tick_q), 32'((cyc % 4) == 0));
      check("idle_state", 32'(state), 32'd0);
      check("idle_da", 32'(da_data), 32'h80);
      check("idle_valid", 32'(da_valid), 32'd0);
      check("idle_rd_en", 32'(fifo_rd_en), 32'd0);
    end

    // Prefill then play.
    for (int i = 0; i < 16; i++) fifo_q.push_back(8'h10 + 8'(i));
    sync_flags();
    enable = 1'b1;
    step();
    check("prefill_state", 32'(state), 32'd1);
    step();
    check("play_state", 32'(state), 32'd2);
    exp_da = 8'h80;
    while (cyc < 34) begin
      step();
      exp_valid = (cyc >= 18) && ((cyc % 4) == 2);
      if (exp_valid) exp_da = 8'h10 + 8'((cyc - 18) / 4);
      check("play_rd_en", 32'(fifo_rd_en), 32'((cyc % 4) == 0));
      check("play_valid", 32'(da_valid), 32'(exp_valid));
      check("play_da", 32'(da_data), 32'(exp_da));
    end

    // Underrun with only two samples left.
    fifo_q = '{8'hA0, 8'hA1};
    sync_flags();
    step_to(36);  check("ur_rd_en_a0", 32'(fifo_rd_en), 32'd1);
    step_to(38);  check("ur_da_a0", 32'(da_data), 32'hA0);
                  check("ur_valid_a0", 32'(da_valid), 32'd1);
    step_to(40);  check("ur_rd_en_a1", 32'(fifo_rd_en), 32'd1);
    step_to(42);  check("ur_da_a1", 32'(da_data), 32'hA1);
    step_to(44);  check("ur_no_rd_en", 32'(fifo_rd_en), 32'd0);
    step();
    check("ur_pulse", 32'(underrun), 32'd1);
    check("ur_cnt", 32'(underrun_cnt), 32'd1);
    check("ur_state", 32'(state), 32'd1);
    check("ur_da_hold", 32'(da_data), 32'hA1);
    check("ur_valid", 32'(da_valid), 32'd0);
    step();
    check("ur_pulse_end", 32'(underrun), 32'd0);
    check("ur_still_prefill", 32'(state), 32'd1);
    fifo_q = '{8'h84, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
    sync_flags();
    step();
    check("ur_resume_play", 32'(state), 32'd2);
    step_to(48);  check("ur_resume_rd_en", 32'(fifo_rd_en), 32'd1);
    step_to(50);  check("ramp_start_da", 32'(da_data), 32'h84);

    // Soft ramp down from 0x84.
    enable = 1'b0;
    step();
    check("ramp_idle", 32'(state), 32'd0);
    exp_da = 8'h84;
    while (cyc < 70) begin
      step();
      exp_valid = (cyc >= 53) && (cyc <= 65) && ((cyc % 4) == 1);
      if (exp_valid) exp_da = exp_da - 8'd1;
      check("ramp_dn_valid", 32'(da_valid), 32'(exp_valid));
      check("ramp_dn_da", 32'(da_data), 32'(exp_da));
    end

    // Soft ramp up from 0x7C.
    fifo_q = '{8'h7C, 8'h90, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
    sync_flags();
    enable = 1'b1;
    step();       check("up_prefill", 32'(state), 32'd1);
    step();       check("up_play", 32'(state), 32'd2);
    step_to(74);  check("up_start_da", 32'(da_data), 32'h7C);
    enable = 1'b0;
    step();       check("up_idle", 32'(state), 32'd0);
    exp_da = 8'h7C;
    while (cyc < 94) begin
      step();
      exp_valid = (cyc >= 77) && (cyc <= 89) && ((cyc % 4) == 1);
      if (exp_valid) exp_da = exp_da + 8'd1;
      check("ramp_up_valid", 32'(da_valid), 32'(exp_valid));
      check("ramp_up_da", 32'(da_data), 32'(exp_da));
    end

    // Disable with a read in flight.
    enable = 1'b1;
    step_to(96);   check("mid_rd_en0", 32'(fifo_rd_en), 32'd1);
    step_to(98);   check("mid_da_90", 32'(da_data), 32'h90);
    step_to(100);  check("mid_rd_en1", 32'(fifo_rd_en), 32'd1);
    step();        check("mid_pending", 32'(dut.rd_pending_q), 32'd1);
    enable = 1'b0;
    step();
    check("mid_state", 32'(state), 32'd0);
    check("mid_da_hold", 32'(da_data), 32'h90);
    check("mid_no_valid", 32'(da_valid), 32'd0);
    step_to(104);  check("mid_da_hold2", 32'(da_data), 32'h90);
    step();
    check("mid_ramp_da", 32'(da_data), 32'h8F);
    check("mid_ramp_valid", 32'(da_valid), 32'd1);

    // Counter saturation and clear.
    force dut.underrun_cnt_q = 16'hFFFD;
    step();
    release dut.underrun_cnt_q;
    step();
    check("sat_preload", 32'(underrun_cnt), 32'hFFFD);
    force_underrun(1'b0);
    check("sat_cnt_fffe", 32'(underrun_cnt), 32'hFFFE);
    force_underrun(1'b0);
    check("sat_cnt_ffff", 32'(underrun_cnt), 32'hFFFF);
    force_underrun(1'b0);
    check("sat_cnt_hold", 32'(underrun_cnt), 32'hFFFF);
    repeat (3) step();
    check("sat_cnt_hold2", 32'(underrun_cnt), 32'hFFFF);
    force_underrun(1'b1);
    check("clr_wins", 32'(underrun_cnt), 32'd0);
    enable = 1'b0;
    repeat (2) step();
    check("end_idle", 32'(state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
